// File: rtl/vu_mult_pkg.sv
// vu_mult_pkg: opcode, FSM state and stage-control types shared by the VU multiplier controller.
// Stage structs carry destination tags of up to VD_W bits.
`default_nettype none

package vu_mult_pkg;

  localparam int         VD_W    = 5;
  localparam logic [3:0] MULD_OP = 4'd6;
  localparam int         ACC_BIT = 3;

  typedef enum logic [3:0] {
    OP_MULF = 4'd0,
    OP_MULU = 4'd1,
    OP_MUDL = 4'd2,
    OP_MUDM = 4'd3,
    OP_MUDN = 4'd4,
    OP_MUDH = 4'd5,
    OP_MULD = 4'd6
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PASS2 = 1'b1
  } state_e;

  // wb marks the pass that delivers a result; MULD pass 1 clears it.
  typedef struct packed {
    logic            sgn;
    logic            unsgn;
    logic            mplr_sgn;
    logic            acc_add;
    logic            shift16;
    logic            rnd;
    logic            illegal;
    logic            wb;
    logic [VD_W-1:0] vd;
  } stage_ctl_t;

  typedef struct packed {
    logic            acc_add;
    logic            shift16;
    logic            rnd;
    logic            illegal;
    logic            wb;
    logic [VD_W-1:0] vd;
  } acc_ctl_t;

  localparam int CTL_W = $bits(stage_ctl_t);

  // Signedness controls are consumed in M1; only accumulator controls travel on.
  function automatic acc_ctl_t to_acc(input stage_ctl_t s);
    acc_ctl_t a;
    a.acc_add = s.acc_add;
    a.shift16 = s.shift16;
    a.rnd     = s.rnd;
    a.illegal = s.illegal;
    a.wb      = s.wb;
    a.vd      = s.vd;
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vumult_ctl_dec.sv
// vumult_ctl_dec: combinational opcode -> stage-control decode; pass2_i selects MULD pass 2.
// VUMULT_CTL_RND_EN enables the rounding-constant injection for MULF/MULU and their MAC forms.
`default_nettype none

module vumult_ctl_dec
  import vu_mult_pkg::*;
(
  input  logic [3:0]       op_code_i,
  input  logic [VD_W-1:0]  vd_i,
  input  logic             pass2_i,
  output logic [CTL_W-1:0] ctl_o
);

  stage_ctl_t ctl;
  logic [3:0] base;
  logic       illegal;

  assign base    = {1'b0, op_code_i[2:0]};
  assign illegal = (op_code_i[2:0] == 3'd7) || (op_code_i == {1'b1, MULD_OP[2:0]});

  always_comb begin
    ctl         = '0;
    ctl.vd      = vd_i;
    ctl.illegal = illegal;
    if (!illegal) begin
      ctl.acc_add = op_code_i[ACC_BIT];
      ctl.wb      = 1'b1;
      case (base)
        OP_MULF: begin
          ctl.sgn      = 1'b1;
          ctl.mplr_sgn = 1'b1;
          ctl.rnd      = 1'b1;
        end
        OP_MULU: ctl.rnd = 1'b1;
        OP_MUDM: ctl.sgn = 1'b1;
        OP_MUDN: ctl.mplr_sgn = 1'b1;
        OP_MUDH: begin
          ctl.sgn      = 1'b1;
          ctl.mplr_sgn = 1'b1;
        end
        // Pass 1: low u x u half; pass 2: signed upper half added in at <<16.
        OP_MULD: begin
          ctl.sgn     = pass2_i;
          ctl.acc_add = pass2_i;
          ctl.shift16 = pass2_i;
          ctl.wb      = pass2_i;
        end
        default: ;
      endcase
    end
`ifndef VUMULT_CTL_RND_EN
    ctl.rnd = 1'b0;
`endif
    ctl.unsgn = !ctl.sgn;
  end

  assign ctl_o = ctl;

endmodule

`default_nettype wire

// File: rtl/vumult_ctl.sv
// vumult_ctl: issue/pipeline controller for the VU 16x16 multiplier (M1, M2, M3) with MULD sequencing.
// Optional VUMULT_CTL_RND_EN (decoded in vumult_ctl_dec) enables rnd_inj.
`default_nettype none

module vumult_ctl
  import vu_mult_pkg::*;
#(
  parameter int TAGW = VD_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [3:0]      op_code,
  input  logic [TAGW-1:0] op_vd,
  input  logic            stall,
  input  logic            flush,
  output logic            m1_sgnmlpcnd,
  output logic            m1_unsgnmlpcnd,
  output logic            m1_mplr_sgn,
  output logic            m1_mpldinvmu,
  output logic            m2_valid,
  output logic            acc_we,
  output logic            acc_add,
  output logic            acc_shift16,
  output logic            rnd_inj,
  output logic            wb_valid,
  output logic [TAGW-1:0] wb_vd,
  output logic            err,
  output logic            busy
);

  state_e          state_q, state_d;
  logic            m1_v_q, m1_v_d, m2_v_q, m2_v_d, m3_v_q, m3_v_d;
  stage_ctl_t      m1_q, m1_d;
  acc_ctl_t        m2_q, m2_d, m3_q, m3_d;
  logic [VD_W-1:0] tag_q, tag_d;

  logic [CTL_W-1:0] dec_ctl;
  stage_ctl_t       dec_s;
  logic             accept, pass2, gate;

  assign pass2    = (state_q == ST_PASS2);
  assign op_ready = !reset && !stall && !flush && (state_q == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign gate     = !stall && !flush;

  // In PASS2 the decoder replays the held MULD tag instead of the decode-stage input.
  vumult_ctl_dec u_dec (
    .op_code_i (pass2 ? MULD_OP : op_code),
    .vd_i      (pass2 ? tag_q : VD_W'(op_vd)),
    .pass2_i   (pass2),
    .ctl_o     (dec_ctl)
  );
  assign dec_s = dec_ctl;

  always_comb begin
    state_d = state_q;
    m1_v_d  = m1_v_q;
    m2_v_d  = m2_v_q;
    m3_v_d  = m3_v_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    m3_d    = m3_q;
    tag_d   = tag_q;
    if (flush) begin
      m1_v_d  = 1'b0;
      m2_v_d  = 1'b0;
      m3_v_d  = 1'b0;
      state_d = ST_IDLE;
    end else if (!stall) begin
      m1_v_d = accept || pass2;
      m1_d   = dec_s;
      m2_v_d = m1_v_q;
      m2_d   = to_acc(m1_q);
      m3_v_d = m2_v_q;
      m3_d   = m2_q;
      if (accept) tag_d = VD_W'(op_vd);
      case (state_q)
        ST_IDLE:  if (accept && (op_code == MULD_OP)) state_d = ST_PASS2;
        ST_PASS2: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m1_v_q  <= 1'b0;
      m2_v_q  <= 1'b0;
      m3_v_q  <= 1'b0;
      m1_q    <= '0;
      m2_q    <= '0;
      m3_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      m1_v_q  <= m1_v_d;
      m2_v_q  <= m2_v_d;
      m3_v_q  <= m3_v_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      m3_q    <= m3_d;
      tag_q   <= tag_d;
    end
  end

  assign m1_sgnmlpcnd   = m1_v_q && m1_q.sgn;
  assign m1_unsgnmlpcnd = m1_v_q && m1_q.unsgn;
  assign m1_mplr_sgn    = m1_v_q && m1_q.mplr_sgn;
  assign m1_mpldinvmu   = m1_v_q && !m1_q.mplr_sgn;
  assign m2_valid       = m2_v_q;

  // Side-effecting strobes are suppressed while the pipe is frozen or being killed.
  assign acc_we      = m3_v_q && !m3_q.illegal && gate;
  assign wb_valid    = m3_v_q && m3_q.wb && !m3_q.illegal && gate;
  assign err         = m3_v_q && m3_q.illegal && gate;
  assign acc_add     = m3_v_q && m3_q.acc_add;
  assign acc_shift16 = m3_v_q && m3_q.shift16;
  assign rnd_inj     = m3_v_q && m3_q.rnd;
  assign wb_vd       = TAGW'(m3_q.vd);
  assign busy        = m1_v_q || m2_v_q || m3_v_q || (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vumult_ctl.sv
// tb_vumult_ctl: randomized op/stall/flush/reset traffic against an age-list model of the multiplier pipe.
`timescale 1ns/1ps
`default_nettype none

module tb_vumult_ctl;

  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            reset, op_valid, stall, flush;
  logic [3:0]      op_code;
  logic [TAGW-1:0] op_vd;
  logic            op_ready, m1_sgnmlpcnd, m1_unsgnmlpcnd, m1_mplr_sgn, m1_mpldinvmu;
  logic            m2_valid, acc_we, acc_add, acc_shift16, rnd_inj, wb_valid, err, busy;
  logic [TAGW-1:0] wb_vd;

  always #5 clk = ~clk;

  vumult_ctl #(.TAGW(TAGW)) dut (
    .clk            (clk),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_code        (op_code),
    .op_vd          (op_vd),
    .stall          (stall),
    .flush          (flush),
    .m1_sgnmlpcnd   (m1_sgnmlpcnd),
    .m1_unsgnmlpcnd (m1_unsgnmlpcnd),
    .m1_mplr_sgn    (m1_mplr_sgn),
    .m1_mpldinvmu   (m1_mpldinvmu),
    .m2_valid       (m2_valid),
    .acc_we         (acc_we),
    .acc_add        (acc_add),
    .acc_shift16    (acc_shift16),
    .rnd_inj        (rnd_inj),
    .wb_valid       (wb_valid),
    .wb_vd          (wb_vd),
    .err            (err),
    .busy           (busy)
  );

  // An op in flight: age 1 = in M1, 2 = in M2, 3 = in M3.
  typedef struct {
    logic [3:0]      code;
    logic [TAGW-1:0] vd;
    bit              p2;
    int              age;
  } ent_t;

  ent_t            q[$];
  bit              pend;
  logic [TAGW-1:0] pend_vd;
  int              n_vec = 0;
  int              n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit f_illegal(input logic [3:0] c);
    return (c == 4'd7) || (c >= 4'd14);
  endfunction

  function automatic bit f_mcand_s(input ent_t e);
    if (e.code == 4'd6) return e.p2;
    return e.code[2:0] inside {3'd0, 3'd3, 3'd5};
  endfunction

  function automatic bit f_mplr_s(input ent_t e);
    if (e.code == 4'd6) return 1'b0;
    return e.code[2:0] inside {3'd0, 3'd4, 3'd5};
  endfunction

  function automatic bit f_add(input ent_t e);
    if (e.code == 4'd6) return e.p2;
    return e.code[3];
  endfunction

  function automatic bit f_rnd(input ent_t e);
`ifdef VUMULT_CTL_RND_EN
    return e.code[2:0] inside {3'd0, 3'd1};
`else
    return (e.code == 4'd15) && (e.code == 4'd0);
`endif
  endfunction

  function automatic bit f_wb(input ent_t e);
    return !f_illegal(e.code) && !((e.code == 4'd6) && !e.p2);
  endfunction

  task automatic model_edge();
    if (reset || flush) begin
      q.delete();
      pend = 1'b0;
    end else if (!stall) begin
      ent_t nq[$];
      foreach (q[i]) begin
        if (q[i].age < 3) begin
          ent_t e = q[i];
          e.age++;
          nq.push_back(e);
        end
      end
      if (pend) begin
        nq.push_back('{code: 4'd6, vd: pend_vd, p2: 1'b1, age: 1});
        pend = 1'b0;
      end else if (op_valid) begin
        nq.push_back('{code: op_code, vd: op_vd, p2: 1'b0, age: 1});
        if (op_code == 4'd6) begin
          pend    = 1'b1;
          pend_vd = op_vd;
        end
      end
      q = nq;
    end
  endtask

  task automatic compare_all();
    bit   h1 = 0, h2 = 0, h3 = 0, gate, ill;
    ent_t e1, e3;
    foreach (q[i]) begin
      if (q[i].age == 1) begin h1 = 1; e1 = q[i]; end
      if (q[i].age == 2) h2 = 1;
      if (q[i].age == 3) begin h3 = 1; e3 = q[i]; end
    end
    gate = !stall && !flush;
    check("op_ready", 32'(op_ready), 32'(!reset && !stall && !flush && !pend));
    check("busy", 32'(busy), 32'((q.size() != 0) || pend));
    check("m2_valid", 32'(m2_valid), 32'(h2));
    if (h1 && !f_illegal(e1.code)) begin
      check("m1_sgnmlpcnd", 32'(m1_sgnmlpcnd), 32'(f_mcand_s(e1)));
      check("m1_unsgnmlpcnd", 32'(m1_unsgnmlpcnd), 32'(!f_mcand_s(e1)));
      check("m1_mplr_sgn", 32'(m1_mplr_sgn), 32'(f_mplr_s(e1)));
      check("m1_mpldinvmu", 32'(m1_mpldinvmu), 32'(!f_mplr_s(e1)));
    end else if (h1) begin
      check("m1_onehot", 32'(m1_sgnmlpcnd) + 32'(m1_unsgnmlpcnd), 32'd1);
    end else begin
      check("m1_idle", {28'd0, m1_sgnmlpcnd, m1_unsgnmlpcnd, m1_mplr_sgn, m1_mpldinvmu}, 32'd0);
    end
    if (h3) begin
      ill = f_illegal(e3.code);
      check("acc_we", 32'(acc_we), 32'(!ill && gate));
      check("wb_valid", 32'(wb_valid), 32'(f_wb(e3) && gate));
      check("err", 32'(err), 32'(ill && gate));
      if (!ill) begin
        check("acc_add", 32'(acc_add), 32'(f_add(e3)));
        check("acc_shift16", 32'(acc_shift16), 32'((e3.code == 4'd6) && e3.p2));
        check("rnd_inj", 32'(rnd_inj), 32'(f_rnd(e3)));
        if (f_wb(e3)) check("wb_vd", 32'(wb_vd), 32'(e3.vd));
      end
    end else begin
      check("m3_idle", {26'd0, acc_we, wb_valid, err, acc_add, acc_shift16, rnd_inj}, 32'd0);
    end
  endtask

  task automatic drive();
    reset    = ($urandom_range(0, 199) == 0);
    stall    = ($urandom_range(0, 7) == 0);
    flush    = ($urandom_range(0, 24) == 0);
    op_valid = ($urandom_range(0, 3) != 0);
    op_code  = ($urandom_range(0, 4) == 0) ? 4'd6 : 4'($urandom_range(0, 15));
    op_vd    = TAGW'($urandom);
    if (reset) begin
      q.delete();
      pend = 1'b0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 4'd0;
    op_vd    = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    pend     = 1'b0;
    pend_vd  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    check("rst_wb_vd", 32'(wb_vd), 32'd0);
    @(posedge clk);
    model_edge();
    #1 reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1 drive();
    end
    @(negedge clk);
    compare_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
